// File: rtl/zeroheti_pkg.sv
// zeroheti_pkg: SoC-wide constants shared by the peripheral demux and its completers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Holds the watchdog register offsets, FSM state type, address-map entry and irq index.
package zeroheti_pkg;

  typedef struct packed {
    logic [31:0] base;
    logic [31:0] mask;
  } addr_rule_t;

  typedef struct packed {
    addr_rule_t mtimer;
    addr_rule_t wdt;
  } addr_map_t;

  localparam addr_map_t AddrMap = '{
    mtimer: '{base: 32'h0003_0200, mask: 32'hFFFF_FF00},
    wdt:    '{base: 32'h0003_0300, mask: 32'hFFFF_FF00}
  };

  // Watchdog bark takes irq line 26; external interrupts start one line higher.
  localparam int unsigned IrqWdt     = 26;
  localparam int unsigned IrqExtBase = 27;

  // Register word offsets, i.e. paddr[4:2].
  localparam logic [2:0] WdtOffCtrl   = 3'd0;
  localparam logic [2:0] WdtOffLoad   = 3'd1;
  localparam logic [2:0] WdtOffCount  = 3'd2;
  localparam logic [2:0] WdtOffKick   = 3'd3;
  localparam logic [2:0] WdtOffStatus = 3'd4;
  localparam logic [2:0] WdtOffWindow = 3'd5;

  typedef enum logic [1:0] {
    WdtIdle,
    WdtRun,
    WdtBark,
    WdtBite
  } wdt_state_e;

endpackage

// File: rtl/apb_watchdog_core.sv
// apb_watchdog_core: watchdog FSM, 32-bit down-counter and reset-request pulse timer.
// Latency: start/kick/disable act on the same edge as the triggering register write.
// Backpressure: none; inputs are sampled every cycle.
// Ports: en (next value of CTRL.EN), load, kick (valid key write), window,
//        count, bark_set / bite_done (1-cycle strobes to the register file), reset_req.
module apb_watchdog_core
  import zeroheti_pkg::*;
#(
  parameter int unsigned ResetCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en,
  input  logic [31:0] load,
  input  logic        kick,
  input  logic [31:0] window,
  output logic [31:0] count,
  output logic        bark_set,
  output logic        bite_done,
  output logic        reset_req
);

  localparam int unsigned PulseW = (ResetCycles > 1) ? $clog2(ResetCycles) : 1;
  localparam logic [PulseW-1:0] PulseInit = PulseW'(ResetCycles - 1);

  wdt_state_e        state;
  logic [PulseW-1:0] pulse_q;

  // A kick in the same cycle as expiry wins, so it suppresses the bark strobe.
  assign bark_set  = (state == WdtRun) && en && !kick && (count == '0);
  assign bite_done = (state == WdtBite) && (pulse_q == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state     <= WdtIdle;
      count     <= '0;
      pulse_q   <= '0;
      reset_req <= 1'b0;
    end else begin
      unique case (state)
        WdtIdle: begin
          if (en) begin
            count <= load;
            state <= WdtRun;
          end
        end
        WdtRun, WdtBark: begin
          if (!en) begin
            state <= WdtIdle;          // count stays frozen
          end else if (kick) begin
            if (count > window) begin  // kicked too early
              state     <= WdtBite;
              reset_req <= 1'b1;
              pulse_q   <= PulseInit;
            end else begin
              count <= load;
              state <= WdtRun;
            end
          end else if (count == '0) begin
            if (state == WdtRun) begin
              count <= load;
              state <= WdtBark;
            end else begin
              state     <= WdtBite;
              reset_req <= 1'b1;
              pulse_q   <= PulseInit;
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        WdtBite: begin
          // reset_req stays high for ResetCycles cycles: entry cycle plus PulseInit more.
          if (pulse_q == '0) begin
            reset_req <= 1'b0;
            state     <= WdtIdle;
          end else begin
            pulse_q <= pulse_q - 1'b1;
          end
        end
        default: state <= WdtIdle;
      endcase
    end
  end

endmodule

// File: rtl/apb_watchdog.sv
// apb_watchdog: APB completer with software-kicked watchdog (bark irq, then bite reset request).
// Latency: zero wait states; reads combinational in the access phase, writes land at its end.
// Backpressure: none, pready_o=1 on every access phase.
// Ports: APB (psel/penable/pwrite/paddr/pwdata/prdata/pready/pslverr), irq_o level, reset_req_o pulse.
// Optional WINDOW register at 0x14 when WDT_WINDOW_EN is defined; otherwise 0x14 is unmapped.
module apb_watchdog
  import zeroheti_pkg::*;
#(
  parameter logic [31:0] KickKey     = 32'h5A5A_A5A5,
  parameter int unsigned ResetCycles = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic        pwrite_i,
  input  logic [31:0] paddr_i,
  input  logic [31:0] pwdata_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        irq_o,
  output logic        reset_req_o
);

  logic        access;
  logic [2:0]  off;
  logic        err;
  logic [31:0] rdata;
  logic        wr_ok, ctrl_wr, load_wr, status_wr, kick;
  logic        en_nxt;

  logic        ctrl_en, ctrl_irq_en, ctrl_lock;
  logic [31:0] load_q;
  logic        status_bark, status_bite;
  logic        irq_q;
  logic [31:0] window;
  logic [31:0] count;
  logic        bark_set, bite_done;

  logic unused_addr;
  assign unused_addr = ^{paddr_i[31:5], paddr_i[1:0]};

  assign access = psel_i & penable_i;
  assign off    = paddr_i[4:2];

  always_comb begin
    err   = 1'b0;
    rdata = '0;
    case (off)
      WdtOffCtrl: begin
        rdata = {29'd0, ctrl_lock, ctrl_irq_en, ctrl_en};
        err   = pwrite_i & ctrl_lock;
      end
      WdtOffLoad: begin
        rdata = load_q;
        err   = pwrite_i & ctrl_lock;
      end
      WdtOffCount: begin
        rdata = count;
        err   = pwrite_i;
      end
      WdtOffKick:   err   = pwrite_i & (pwdata_i != KickKey);
      WdtOffStatus: rdata = {30'd0, status_bite, status_bark};
`ifdef WDT_WINDOW_EN
      WdtOffWindow: begin
        rdata = window;
        err   = pwrite_i & ctrl_lock;
      end
`endif
      default: err = 1'b1;
    endcase
  end

  assign pready_o  = access;
  assign pslverr_o = access & err;
  assign prdata_o  = access ? rdata : 32'd0;

  assign wr_ok     = access & pwrite_i & ~err;
  assign ctrl_wr   = wr_ok && (off == WdtOffCtrl);
  assign load_wr   = wr_ok && (off == WdtOffLoad);
  assign status_wr = wr_ok && (off == WdtOffStatus);
  assign kick      = wr_ok && (off == WdtOffKick);

  // The core sees EN's next value so a start lands on the write edge itself.
  // End of bite clears EN even if software writes CTRL in that same cycle.
  assign en_nxt = bite_done ? 1'b0 : (ctrl_wr ? pwdata_i[0] : ctrl_en);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ctrl_en     <= 1'b0;
      ctrl_irq_en <= 1'b0;
      ctrl_lock   <= 1'b0;
      load_q      <= '0;
      status_bark <= 1'b0;
      status_bite <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      ctrl_en <= en_nxt;
      if (ctrl_wr) begin
        ctrl_irq_en <= pwdata_i[1];
        ctrl_lock   <= ctrl_lock | pwdata_i[2];
      end
      if (load_wr) load_q <= pwdata_i;
      if (bark_set) status_bark <= 1'b1;
      else if (status_wr && pwdata_i[0]) status_bark <= 1'b0;
      if (bite_done) status_bite <= 1'b1;
      irq_q <= status_bark & ctrl_irq_en;
    end
  end

`ifdef WDT_WINDOW_EN
  logic window_wr;
  assign window_wr = wr_ok && (off == WdtOffWindow);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) window <= '1;
    else if (window_wr) window <= pwdata_i;
  end
`else
  assign window = '1;  // all kicks are in-window
`endif

  assign irq_o = irq_q;

  apb_watchdog_core #(
    .ResetCycles(ResetCycles)
  ) u_core (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en       (en_nxt),
    .load     (load_q),
    .kick     (kick),
    .window   (window),
    .count    (count),
    .bark_set (bark_set),
    .bite_done(bite_done),
    .reset_req(reset_req_o)
  );

endmodule
